// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if: PE-side command/data handshakes plus router Local-port
// flit/credit wires for the packetizer.
//   slave  modport: the packetizer (accepts commands/data, drives flits)
//   master modport: PE + router side (offers commands/data, returns credits)
// Signals: cmd_valid/cmd_ready/cmd_dst/cmd_len, data_valid/data_ready/data_in,
//          credit_in, valid_out, TX, busy, credit_cnt.
interface ni_packetizer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NoC_size    = 4,
  parameter int CREDIT_INIT = 4
);
  localparam int CW = $clog2(CREDIT_INIT + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [NoC_size-1:0]   cmd_dst;
  logic [11:0]           cmd_len;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-4:0] data_in;
  logic                  credit_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] TX;
  logic                  busy;
  logic [CW-1:0]         credit_cnt;

  modport slave (
    input  cmd_valid, cmd_dst, cmd_len, data_valid, data_in, credit_in,
    output cmd_ready, data_ready, valid_out, TX, busy, credit_cnt
  );

  modport master (
    output cmd_valid, cmd_dst, cmd_len, data_valid, data_in, credit_in,
    input  cmd_ready, data_ready, valid_out, TX, busy, credit_cnt
  );
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns a PE command (dst, len) plus payload words into a
// header/body.../tail flit packet for the router Local input port, with
// credit-based flow control against the router input FIFO.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   bus          ni_packetizer_if.slave (command, data, flit, credit, status)
//   credit_err   sticky credit-overflow flag, only when NI_CREDIT_CHECK_EN
//                is defined
// Optional feature macro: NI_CREDIT_CHECK_EN
module ni_packetizer #(
  parameter int DATA_WIDTH      = 32,
  parameter int current_address = 0,
  parameter int NoC_size        = 4,
  parameter int CREDIT_INIT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  ni_packetizer_if.slave   bus
`ifdef NI_CREDIT_CHECK_EN
  ,
  output logic             credit_err
`endif
);
  localparam int CW = $clog2(CREDIT_INIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_INIT);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [11:0]           rem;
  logic [11:0]           len_n, len_p1;
  logic                  has_credit, last_word;
  logic                  cmd_fire, data_fire, issue;
  logic [DATA_WIDTH-1:0] hdr;

  assign has_credit = (cnt != '0);
  assign last_word  = (rem <= 12'd1);
  assign issue      = cmd_fire | data_fire;

  // Zero-length commands still carry one payload word in the tail.
  assign len_n  = (bus.cmd_len == 12'd0) ? 12'd1 : bus.cmd_len;
  assign len_p1 = len_n + 12'd1;

  always_comb begin
    hdr = '0;
    hdr[DATA_WIDTH-1 -: 3]            = 3'b001;
    hdr[DATA_WIDTH-4 -: 12]           = len_p1;
    hdr[DATA_WIDTH-19 +: NoC_size]    = bus.cmd_dst;
    hdr[DATA_WIDTH-19-NoC_size +: NoC_size] = NoC_size'(current_address);
  end

  // Readies look only at state and the registered count; gating with reset
  // keeps them low while reset is held and lets cmd_ready rise as soon as
  // reset is released.
  always_comb begin
    state_nxt      = state;
    bus.cmd_ready  = 1'b0;
    bus.data_ready = 1'b0;
    cmd_fire       = 1'b0;
    data_fire      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = reset && has_credit;
        cmd_fire      = bus.cmd_valid && reset && has_credit;
        if (cmd_fire) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        bus.data_ready = reset && has_credit;
        data_fire      = bus.data_valid && reset && has_credit;
        if (data_fire && last_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.TX        <= '0;
      bus.valid_out <= 1'b0;
      rem           <= '0;
    end else begin
      bus.valid_out <= issue;
      if (cmd_fire) begin
        bus.TX <= hdr;
        rem    <= len_n;
      end else if (data_fire) begin
        bus.TX <= {(last_word ? 3'b100 : 3'b010), bus.data_in};
        rem    <= rem - 12'd1;
      end
    end
  end

  // Issue and credit in the same cycle cancel; a credit at full count is
  // dropped (saturate).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= CMAX;
    else if (issue && !bus.credit_in) cnt <= cnt - 1'b1;
    else if (!issue && bus.credit_in && cnt != CMAX) cnt <= cnt + 1'b1;
  end

`ifdef NI_CREDIT_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) credit_err <= 1'b0;
    else if (bus.credit_in && cnt == CMAX) credit_err <= 1'b1;
  end
`endif

  assign bus.busy       = (state == PAYLOAD);
  assign bus.credit_cnt = cnt;
endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Transmit-side network interface between a local processing element (PE) and the router's Local input port. It turns a PE command (destination, payload length) and a stream of payload words into a header/body/tail flit packet. Flits go out on the router's `RX_L`/`valid_in_L` pair. The block counts the router's returned `credit_out_L` pulses so it never overruns the Local input FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 32: flit width; the top 3 bits are the flit type.
- `current_address`, 0: this node's address, placed in the header source field.
- `NoC_size`, 4: width in bits of the source and destination address fields.
- `CREDIT_INIT`, 4: credits at reset; equals the router input FIFO depth.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: the PE offers a packet command.
- `cmd_ready`  out  1: the command is accepted when `cmd_valid & cmd_ready` is high at a rising edge.
- `cmd_dst`  in  `NoC_size`: destination node address.
- `cmd_len`  in  12: number of payload words N.
- `data_valid`  in  1: the PE offers a payload word.
- `data_ready`  out  1: the payload word is accepted when `data_valid & data_ready` is high at a rising edge.
- `data_in`  in  `DATA_WIDTH-3`: payload word.
- `credit_in`  in  1: one-cycle pulse, one per flit the router has drained; connects to router `credit_out_L`.
- `valid_out`  out  1: one-cycle pulse per flit; connects to router `valid_in_L`.
- `TX`  out  `DATA_WIDTH`: the flit; connects to router `RX_L`.
- `busy`  out  1: high while a packet is in progress.
- `credit_cnt`  out  `$clog2(CREDIT_INIT+1)`: current credit count.

## Operation
Flit type, bits `[DATA_WIDTH-1:DATA_WIDTH-3]`:
- `001` header, `010` body, `100` tail.

Header field layout:
- Bits `[DATA_WIDTH-4:DATA_WIDTH-15]`: packet length = N+1 flits in total.
- Bits `[DATA_WIDTH-19 +: NoC_size]`: `cmd_dst`. This is the field the router's route computation decodes.
- Bits `[DATA_WIDTH-19-NoC_size +: NoC_size]`: `current_address`.
- All remaining bits are 0.

Body and tail flits:
- Type bits followed by `data_in` unchanged.

Packet structure and length rules:
- A packet is one header, then N-1 body flits, then one tail flit. The last payload word travels in the tail.
- `cmd_len` = 0 is coerced to N = 1, giving a 2-flit packet.
- N is latched when the command is accepted.

State machine:
- IDLE:
  - `cmd_ready` = (credit_cnt > 0).
  - On command handshake: register the header into `TX`, pulse `valid_out`, load the remaining-word counter with N, go to PAYLOAD.
- PAYLOAD:
  - `data_ready` = (credit_cnt > 0).
  - On each data handshake: register a body flit if remaining > 1, otherwise a tail flit; pulse `valid_out`; decrement remaining.
  - After the tail flit, go to IDLE.
- `cmd_ready` is 0 in PAYLOAD; `data_ready` is 0 in IDLE.
- `busy` = (state == PAYLOAD).

Credit counter:
- next = cnt − issue + `credit_in`, where issue is 1 in any cycle that emits a flit.
- An issue and a credit in the same cycle leave the count unchanged.
- A `credit_in` arriving in a given cycle does not enable an issue in that same cycle; ready decisions use the registered count only.
- A `credit_in` arriving while cnt == `CREDIT_INIT` saturates: the count stays at `CREDIT_INIT`.

Reset:
- `TX` = 0, `valid_out` = 0, `cmd_ready` = 0, `data_ready` = 0, `busy` = 0, `credit_cnt` = `CREDIT_INIT`, state = IDLE.
- Once reset is released, `cmd_ready` becomes 1 combinationally.
- Reset asserted mid-packet aborts the packet immediately, with no tail sent. A system-wide reset is required to clear the router at the same time.

## Timing
- A handshake at edge k produces `TX`/`valid_out` valid from edge k until edge k+1. `valid_out` is high for exactly one cycle per flit.
- `TX` holds the last flit value while `valid_out` is 0.
- Peak throughput is 1 flit/cycle while credits are available. An N-word packet with no stalls takes N+1 consecutive cycles.
- The command handshake and the first data handshake can never occur in the same cycle.
- `cmd_ready` and `data_ready` are combinational from state and the registered count. They do not depend on `cmd_valid` or `data_valid`.

## Configuration
- `NI_CREDIT_CHECK_EN` defined:
  - Adds output `credit_err` (1 bit, reset 0).
  - `credit_err` sets sticky when `credit_in` arrives at cnt == `CREDIT_INIT` and clears only on reset.
  - The counter still saturates.
- `NI_CREDIT_CHECK_EN` undefined: the `credit_err` port is absent and overflow is silently saturated.

## Test plan
- Reset, then cmd dst=5, len=3, PE data always valid, `credit_in` held 0:
  - 4 consecutive flits: header with length field 4 and dst bits = 5, then body, body, tail.
  - `credit_cnt` ends at 0; `data_ready` stays 0 until a credit arrives.
- cmd len=0: header with length 2, then a tail carrying the single payload word; `busy` is 1 for exactly one cycle.
- Credits exhausted in PAYLOAD: pulse `credit_in` once; exactly one more flit leaves, 1 cycle after the pulse.
- Issue and `credit_in` in the same cycle with cnt=2: cnt stays 2 and no flit is lost.
- Reset asserted after the 2nd flit of a 5-flit packet:
  - `valid_out` = 0 and `TX` = 0 immediately, `credit_cnt` = 4, state IDLE.
  - The next command starts with a header.
- `credit_in` pulsed at cnt=4: cnt stays 4; with `NI_CREDIT_CHECK_EN` defined, `credit_err` rises next edge and stays 1.
